// File: rtl/mem_lsu.sv
// Load/store unit in front of the dual-port 24/48-bit memory: issues at most one access per cycle
// on the port opposite the current phase and returns in-order responses through a small FIFO.
`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif

module mem_lsu #(
    parameter int MEM_WORDS = 4096,
    parameter int RSP_DEPTH = 4
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic                iw_req_valid,
    output logic                ow_req_ready,
    input  logic                iw_req_we,
    input  logic                iw_req_is48,
    input  logic [`HBIT_ADDR:0] iw_req_addr,
    input  logic [`HBIT_ADDR:0] iw_req_wdata,
    output logic                or_mem_we    [0:1],
    output logic [`HBIT_ADDR:0] or_mem_addr  [0:1],
    output logic [`HBIT_ADDR:0] or_mem_wdata [0:1],
    output logic                or_mem_is48  [0:1],
    input  logic [`HBIT_ADDR:0] iw_mem_rdata [0:1],
    output logic                ow_rsp_valid,
    input  logic                iw_rsp_ready,
    output logic [`HBIT_ADDR:0] ow_rsp_rdata,
    output logic                ow_rsp_we,
    output logic                ow_rsp_err
);
    localparam int AW = `HBIT_ADDR + 1;
    localparam int HW = AW / 2;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic          r_mp;
    logic [CW-1:0] r_cnt;
    logic          r_s1_valid, r_s1_port, r_s1_we, r_s1_is48, r_s1_err;
    logic          r_s2_valid, r_s2_port, r_s2_we, r_s2_is48, r_s2_err;
    logic [CW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW-1:0] r_fifo_data [RSP_DEPTH];
    logic          r_fifo_we   [RSP_DEPTH];
    logic          r_fifo_err  [RSP_DEPTH];

    logic          w_fault, w_accept, w_issue, w_push, w_pop;
    logic          w_port_sel [0:1];
    logic [AW-1:0] w_rdata_sel, w_push_data;

    // Full-width compares so huge addresses never alias into the array
    assign w_fault      = (iw_req_addr >= AW'(MEM_WORDS)) ||
                          (iw_req_is48 && (iw_req_addr == AW'(MEM_WORDS - 1)));
    assign ow_req_ready = !iw_rst && (r_cnt < CW'(RSP_DEPTH));
    assign w_accept     = iw_req_valid && ow_req_ready;
    assign w_issue      = w_accept && !w_fault;
    assign ow_rsp_valid = (r_wr_ptr != r_rd_ptr);
    assign w_pop        = ow_rsp_valid && iw_rsp_ready;
    assign w_push       = r_s2_valid && !iw_rst;
    assign w_rdata_sel  = iw_mem_rdata[r_s2_port];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port_sel
            // Next access lands on the port opposite the current phase
            assign w_port_sel[gi] = w_issue && (r_mp != 1'(gi));
        end
    endgenerate

    always_comb begin
        w_push_data = '0;
        if (!r_s2_we && !r_s2_err)
            w_push_data = r_s2_is48 ? w_rdata_sel : {{HW{1'b0}}, w_rdata_sel[HW-1:0]};
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_mp       <= 1'b0;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < 2; i++) begin
                or_mem_we[i]    <= 1'b0;
                or_mem_addr[i]  <= '0;
                or_mem_wdata[i] <= '0;
                or_mem_is48[i]  <= 1'b0;
            end
        end else begin
            r_mp       <= ~r_mp;
            r_cnt      <= r_cnt + CW'(w_accept) - CW'(w_pop);
            r_s1_valid <= w_accept;
            r_s1_port  <= ~r_mp;
            r_s1_we    <= iw_req_we;
            r_s1_is48  <= iw_req_is48;
            r_s1_err   <= w_fault;
            r_s2_valid <= r_s1_valid;
            r_s2_port  <= r_s1_port;
            r_s2_we    <= r_s1_we;
            r_s2_is48  <= r_s1_is48;
            r_s2_err   <= r_s1_err;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (w_port_sel[i]) begin
                    or_mem_we[i]    <= iw_req_we;
                    or_mem_addr[i]  <= iw_req_addr;
                    or_mem_wdata[i] <= iw_req_wdata;
                    or_mem_is48[i]  <= iw_req_is48;
                end else begin
                    or_mem_we[i]    <= 1'b0;
                    or_mem_addr[i]  <= '0;
                    or_mem_wdata[i] <= '0;
                    or_mem_is48[i]  <= 1'b0;
                end
            end
        end
    end

    // Response storage; r_cnt guarantees a free slot for every push
    always_ff @(posedge iw_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr[PW-1:0]] <= w_push_data;
            r_fifo_we[r_wr_ptr[PW-1:0]]   <= r_s2_we;
            r_fifo_err[r_wr_ptr[PW-1:0]]  <= r_s2_err;
        end
    end

    assign ow_rsp_rdata = r_fifo_data[r_rd_ptr[PW-1:0]];
    assign ow_rsp_we    = r_fifo_we[r_rd_ptr[PW-1:0]];
    assign ow_rsp_err   = r_fifo_err[r_rd_ptr[PW-1:0]];

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the dual-port 24/48-bit memory; it owns both memory ports and issues one access per cycle.
- Accepts in-order 24/48-bit load/store requests over a valid/ready handshake.
- Drives the alternating port phase: the port opposite the current phase receives the next access.
- Captures the registered memory read data and returns in-order responses through a response FIFO with backpressure.

Parameters:
- MEM_WORDS, 4096, number of 24-bit words in the attached memory; bounds-check limit.
- RSP_DEPTH, 4, response FIFO depth and maximum outstanding requests (power of two, >=2).

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  synchronous active-high reset.
- iw_req_valid  in  1  request valid.
- ow_req_ready  out  1  request accepted when valid&ready at a rising edge.
- iw_req_we  in  1  1=store, 0=load.
- iw_req_is48  in  1  1=48-bit access, 0=24-bit access.
- iw_req_addr  in  `HBIT_ADDR+1  word address.
- iw_req_wdata  in  `HBIT_ADDR+1  store data; low 24 bits go to addr, high 24 bits to addr+1.
- or_mem_we[0:1]  out  1 each  per-port write enable to the memory.
- or_mem_addr[0:1]  out  `HBIT_ADDR+1 each  per-port address.
- or_mem_wdata[0:1]  out  `HBIT_ADDR+1 each  per-port write data.
- or_mem_is48[0:1]  out  1 each  per-port width select.
- iw_mem_rdata[0:1]  in  `HBIT_ADDR+1 each  registered memory read data.
- ow_rsp_valid  out  1  FIFO head valid.
- iw_rsp_ready  in  1  head popped when valid&ready.
- ow_rsp_rdata  out  `HBIT_ADDR+1  load data (upper 24 bits zero for 24-bit loads); 0 for stores.
- ow_rsp_we  out  1  echo of request type.
- ow_rsp_err  out  1  bounds fault; no memory access was performed.

Behaviour:
- **Port phase.** r_mp resets to 0 and toggles every cycle while not in reset.
- **Acceptance.**
  - Outstanding counter cnt: +1 on accept, -1 on response pop, both in the same cycle gives net 0.
  - ow_req_ready = !iw_rst && cnt < RSP_DEPTH.
- **Issue.** A request accepted in cycle A is loaded at the edge into the port-p issue registers, with p = ~r_mp(A).
  - In cycle A+1, r_mp == p and port p drives we/addr/wdata/is48.
  - The other port drives all zeros.
  - Any port with no issued access drives all zeros, including we=0.
- **Fault.** Fault = addr >= MEM_WORDS, or (is48 && addr == MEM_WORDS-1).
  - A faulted request issues nothing: the port stays idle.
  - It still flows through the pipeline and produces a response with err=1, rdata=0.
- **Capture.** The port index, we and err are piped alongside the access.
  - In A+2, iw_mem_rdata[p] is written into the FIFO together with we and err.
  - For stores and faults the FIFO data is forced to 0.
- **Response timing.** With an empty FIFO, ow_rsp_valid rises in A+3 (3-cycle latency).
  - Throughput is one request per cycle.
  - Responses are strictly in request order.
- **Overflow.** The FIFO cannot overflow: cnt bounds in-flight plus stored entries to RSP_DEPTH.
  - FIFO pointers wrap modulo RSP_DEPTH.
  - Simultaneous push and pop at full or empty behaves normally; there is no fall-through.
- **Hazards.** Store followed by a load to the same address in the next cycle needs no interlock: the write commits at the edge before the load's cycle.
- **Reset.**
  - Clears r_mp, cnt, FIFO pointers, the pipe valids and all or_mem_* outputs; ow_rsp_valid=0 the cycle after.
  - An access already driven during the cycle iw_rst is high still reaches the memory at that edge.
  - Its response is discarded.
  - No request is accepted in a reset cycle.
- **Width.** Address comparisons use the full `HBIT_ADDR+1 width; no wrap of addr+1 past MEM_WORDS-1.

Test Plan:
1. Store 24-bit addr=5 data=0xABCDEF, then load 24-bit addr=5 on the next cycle.
   - Port we pulse on alternating ports.
   - Load response rdata=0x000000ABCDEF, err=0.
   - Each response arrives 3 cycles after its acceptance.
2. Store 48-bit addr=10 data=0x111111222222, then load 24-bit addr=11.
   - Store: or_mem_is48=1 on its port.
   - Load: rdata=0x111111.
3. Loads at addr=4095 is48=1 and at addr=4096.
   - No or_mem_we/addr activity.
   - Both responses have err=1, rdata=0.
   - A following valid load at addr=4095 24-bit gives err=0.
4. Backpressure: hold iw_rsp_ready=0 and issue 6 back-to-back loads.
   - Exactly 4 are accepted; ow_req_ready=0 thereafter.
   - Raising ready pops them in order, one per cycle.
   - Each pop re-enables one acceptance.
5. Streaming: 8 alternating loads/stores with iw_rsp_ready=1.
   - One accept per cycle.
   - Port index alternates 0/1.
   - Responses are in order with correct data.
6. Assert iw_rst for one cycle with 2 requests in flight and 1 in the FIFO.
   - ow_rsp_valid=0 and cnt=0 after reset.
   - r_mp restarts at 0.
   - The next request completes with 3-cycle latency.
